// File: rtl/gpio_disp_pkg.sv
// Shared FSM state type and active-low seven-segment codes for the GPIO decimal display.
package gpio_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/seg7_encode.sv
// One BCD digit to active-low segments; non-decimal codes and forced blanking give a dark digit.
module seg7_encode
  import gpio_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Digit lookup with blanking override.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_DIGIT[0];
        4'd1:    seg = SEG_DIGIT[1];
        4'd2:    seg = SEG_DIGIT[2];
        4'd3:    seg = SEG_DIGIT[3];
        4'd4:    seg = SEG_DIGIT[4];
        4'd5:    seg = SEG_DIGIT[5];
        4'd6:    seg = SEG_DIGIT[6];
        4'd7:    seg = SEG_DIGIT[7];
        4'd8:    seg = SEG_DIGIT[8];
        4'd9:    seg = SEG_DIGIT[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/gpio_bcd_display.sv
// Watches the GPIO output register, converts each new value to decimal with a
// sequential shift/add-3 engine and drives NDIG seven-segment digits.
module gpio_bcd_display
  import gpio_disp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NDIG     = 8,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   gpio_in,
  output logic               busy,
  output logic               ovf,
  output logic [4*NDIG-1:0]  bcd_out,
  output logic [7*NDIG-1:0]  hex_out
);

  localparam int NBCD  = (WIDTH * 30103) / 100000 + 1;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  disp_state_e          state_r;
  logic [WIDTH-1:0]     last_val_r;
  logic [WIDTH-1:0]     shift_r;
  logic [4*NBCD-1:0]    acc_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 ovf_r;
  logic [4*NDIG-1:0]    bcd_r;
  logic [7*NDIG-1:0]    hex_r;

  logic [4*NBCD-1:0]    acc_adj_s;
  logic                 ovf_next_s;
  logic [NDIG-1:0]      blank_s;
  logic                 zero_run_s;
  logic [7*NDIG-1:0]    hex_next_s;

  for (genvar g = 0; g < NBCD; g++) begin : g_add3
    assign acc_adj_s[4*g +: 4] = (acc_r[4*g +: 4] >= 4'd5) ? (acc_r[4*g +: 4] + 4'd3)
                                                           : acc_r[4*g +: 4];
  end

  if (NBCD > NDIG) begin : g_ovf
    assign ovf_next_s = |acc_r[4*NBCD-1:4*NDIG];
  end else begin : g_no_ovf
    assign ovf_next_s = 1'b0;
  end

  // Leading-zero blanking over the displayed digits; overflow shows everything.
  always_comb begin
    zero_run_s = 1'b1;
    blank_s    = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (acc_r[4*i +: 4] == 4'd0);
      blank_s[i] = (i != 0) && (BLANK_LZ != 0) && !ovf_next_s && zero_run_s;
    end
  end

  for (genvar d = 0; d < NDIG; d++) begin : g_seg
    seg7_encode u_seg (
      .bcd   (acc_r[4*d +: 4]),
      .blank (blank_s[d]),
      .seg   (hex_next_s[7*d +: 7])
    );
  end

  // Conversion FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      last_val_r <= '0;
      shift_r    <= '0;
      acc_r      <= '0;
      cnt_r      <= '0;
      ovf_r      <= 1'b0;
      bcd_r      <= '0;
      for (int i = 0; i < NDIG; i++) begin
        hex_r[7*i +: 7] <= ((i == 0) || (BLANK_LZ == 0)) ? SEG_DIGIT[0] : SEG_BLANK;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gpio_in != last_val_r) begin
            last_val_r <= gpio_in;
            shift_r    <= gpio_in;
            acc_r      <= '0;
            cnt_r      <= '0;
            state_r    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_r   <= {acc_adj_s[4*NBCD-2:0], shift_r[WIDTH-1]};
          shift_r <= shift_r << 1;
          cnt_r   <= cnt_r + 1'b1;
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_r   <= acc_r[4*NDIG-1:0];
          ovf_r   <= ovf_next_s;
          hex_r   <= hex_next_s;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_r != ST_IDLE);
  assign ovf     = ovf_r;
  assign bcd_out = bcd_r;
  assign hex_out = hex_r;

endmodule

// File: tb/tb_gpio_bcd_display.sv
// Directed bench for gpio_bcd_display: conversion latency, BCD/segment results,
// overflow display, mid-conversion changes and reset abort.
module tb_gpio_bcd_display;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpio_in;
  logic        busy;
  logic        ovf;
  logic [31:0] bcd_out;
  logic [55:0] hex_out;

  int checks   = 0;
  int failures = 0;

  gpio_bcd_display #(.WIDTH(32), .NDIG(8), .BLANK_LZ(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gpio_in (gpio_in),
    .busy    (busy),
    .ovf     (ovf),
    .bcd_out (bcd_out),
    .hex_out (hex_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Digits at index >= nshown are expected dark.
  function automatic logic [55:0] exp_hex(input logic [31:0] bcd, input int nshown);
    logic [55:0] h;
    h = '0;
    for (int i = 0; i < 8; i++) begin
      h[7*i +: 7] = (i < nshown) ? seg_of(bcd[4*i +: 4]) : 7'h7F;
    end
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a new value and count sampled busy cycles until the conversion ends.
  task automatic run_conv(input logic [31:0] v, output int n);
    gpio_in = v;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
  endtask

  int n;
  int n2;

  initial begin
    rst_n   = 1'b0;
    gpio_in = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_bcd", {32'd0, bcd_out}, 64'd0);
    chk("rst_hex", {8'd0, hex_out}, {8'd0, exp_hex(32'h0, 1)});
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("zero_no_conv", {63'd0, busy}, 64'd0);

    run_conv(32'h000004D2, n);
    chk("t1234_busy_len", 64'(n), 64'd33);
    chk("t1234_bcd", {32'd0, bcd_out}, {32'd0, 32'h00001234});
    chk("t1234_ovf", {63'd0, ovf}, 64'd0);
    chk("t1234_hex", {8'd0, hex_out}, {8'd0, exp_hex(32'h00001234, 4)});

    run_conv(32'h05F5E0FF, n);
    chk("t9s_busy_len", 64'(n), 64'd33);
    chk("t9s_bcd", {32'd0, bcd_out}, {32'd0, 32'h99999999});
    chk("t9s_ovf", {63'd0, ovf}, 64'd0);
    chk("t9s_hex", {8'd0, hex_out}, {8'd0, exp_hex(32'h99999999, 8)});

    run_conv(32'hFFFFFFFF, n);
    chk("tmax_busy_len", 64'(n), 64'd33);
    chk("tmax_bcd", {32'd0, bcd_out}, {32'd0, 32'h94967295});
    chk("tmax_ovf", {63'd0, ovf}, 64'd1);
    chk("tmax_hex", {8'd0, hex_out}, {8'd0, exp_hex(32'h94967295, 8)});

    // Change 5 -> 7 while busy: 5 is shown first, then 7 after a one-cycle gap.
    gpio_in = 32'd5;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
      if (n == 6) gpio_in = 32'd7;
    end
    chk("t5_busy_len", 64'(n), 64'd33);
    chk("t5_bcd", {32'd0, bcd_out}, {32'd0, 32'h00000005});
    chk("t5_ovf", {63'd0, ovf}, 64'd0);
    chk("t5_hex", {8'd0, hex_out}, {8'd0, exp_hex(32'h5, 1)});
    @(negedge clk);
    chk("gap_one_cycle", {63'd0, busy}, 64'd1);
    n2 = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy) n2++;
      else break;
    end
    chk("t7_busy_len", 64'(n2), 64'd33);
    chk("t7_bcd", {32'd0, bcd_out}, {32'd0, 32'h00000007});
    chk("t7_hex", {8'd0, hex_out}, {8'd0, exp_hex(32'h7, 1)});

    // Reset at busy cycle 10 of a 1234 conversion.
    gpio_in = 32'h000004D2;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy) n++;
      if (n == 10 || (n == 0 && k > 5)) break;
    end
    chk("abort_reached_busy", 64'(n), 64'd10);
    rst_n   = 1'b0;
    gpio_in = 32'h0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_bcd", {32'd0, bcd_out}, 64'd0);
    chk("abort_ovf", {63'd0, ovf}, 64'd0);
    chk("abort_hex", {8'd0, hex_out}, {8'd0, exp_hex(32'h0, 1)});
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_late_busy", {63'd0, busy}, 64'd0);
    chk("abort_no_late_bcd", {32'd0, bcd_out}, 64'd0);
    chk("abort_no_late_hex", {8'd0, hex_out}, {8'd0, exp_hex(32'h0, 1)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
